adder_ds_acc: RTL and testbench

- Downstream consumer of the adder/select datapath register stage.
- Collects the registered result stream `reg_0` (presented here as `in_data`) into fixed-length windows.
- For each window it produces the sum, the maximum and the sample count.
- Each window result is offered on a valid/ready output port with a one-deep holding register. The upstream stage cannot stall, so the input side has no backpressure.

---
 rtl/adder_ds_acc_if.sv | 37 +++
 rtl/adder_ds_acc.sv | 186 ++++++++++++++++++
 tb/tb_adder_ds_acc.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_ds_acc_if.sv
// Window-accumulator bus: upstream sample stream, window controls and the
// valid/ready result port with its sticky overrun flag.
interface adder_ds_acc_if #(
  parameter int N     = 32,
  parameter int WIN_W = 4,
  parameter int ACC_W = N + WIN_W
);

  // Sample stream from the upstream register stage (no backpressure)
  logic             in_valid;
  logic [N-1:0]     in_data;

  // Window controls
  logic [WIN_W-1:0] win_len;
  logic             flush;

  // Result port
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [N-1:0]     out_max;
  logic [WIN_W:0]   out_cnt;
  logic             ovr;

  // Driver side: produces samples and controls, consumes results
  modport master (
    output in_valid, in_data, win_len, flush, out_ready,
    input  out_valid, out_sum, out_max, out_cnt, ovr
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_data, win_len, flush, out_ready,
    output out_valid, out_sum, out_max, out_cnt, ovr
  );

endinterface

// File: rtl/adder_ds_acc.sv
// Window accumulator: gathers the upstream result stream into windows of
// win_len samples and reports sum, maximum and count per window through a
// one-deep valid/ready holding register. A result that finds the holding
// register still occupied is dropped and flagged on the sticky ovr output.
module adder_ds_acc #(
  parameter int N     = 32,
  parameter int WIN_W = 4,
  parameter int ACC_W = N + WIN_W
) (
  input logic          clk,
  input logic          rst_n,
  adder_ds_acc_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // A window length field of zero encodes the largest window, 2^WIN_W
  localparam logic [WIN_W:0] FULL_LEN = {1'b1, {WIN_W{1'b0}}};
  localparam logic [WIN_W:0] ONE_CNT  = {{WIN_W{1'b0}}, 1'b1};

  // Window state
  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [N-1:0]     r_max;
  logic [N-1:0]     w_max_nxt;
  logic [WIN_W:0]   r_cnt;
  logic [WIN_W:0]   w_cnt_nxt;
  logic [WIN_W:0]   r_len;
  logic [WIN_W:0]   w_len_nxt;

  // Completed-window result, valid only while w_done is high
  logic             w_done;
  logic [ACC_W-1:0] w_done_sum;
  logic [N-1:0]     w_done_max;
  logic [WIN_W:0]   w_done_cnt;

  // Datapath helpers
  logic [WIN_W:0]   w_len_eff;
  logic [ACC_W-1:0] w_sample_ext;
  logic [ACC_W-1:0] w_acc_add;
  logic [N-1:0]     w_max_upd;
  logic [WIN_W:0]   w_cnt_inc;

  // Output holding register
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [N-1:0]     r_out_max;
  logic [WIN_W:0]   r_out_cnt;
  logic             r_ovr;
  logic             w_load;
  logic             w_drop;

  // Effective window length and the arithmetic for absorbing one more sample
  always_comb begin
    w_len_eff    = (bus.win_len == '0) ? FULL_LEN : {1'b0, bus.win_len};
    w_sample_ext = ACC_W'(bus.in_data);
    w_acc_add    = r_acc + w_sample_ext;
    w_max_upd    = (bus.in_data > r_max) ? bus.in_data : r_max;
    w_cnt_inc    = r_cnt + ONE_CNT;
  end

  // Next window state and window-completion detect; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_max_nxt   = r_max;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_done      = 1'b0;
    w_done_sum  = '0;
    w_done_max  = '0;
    w_done_cnt  = '0;

    if (bus.flush) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_max_nxt   = '0;
      w_cnt_nxt   = '0;
      w_len_nxt   = '0;
    end else if (bus.in_valid) begin
      case (r_state)
        IDLE: begin
          if (w_len_eff == ONE_CNT) begin
            w_done      = 1'b1;
            w_done_sum  = w_sample_ext;
            w_done_max  = bus.in_data;
            w_done_cnt  = ONE_CNT;
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_max_nxt   = '0;
            w_cnt_nxt   = '0;
            w_len_nxt   = '0;
          end else begin
            w_state_nxt = ACCUM;
            w_acc_nxt   = w_sample_ext;
            w_max_nxt   = bus.in_data;
            w_cnt_nxt   = ONE_CNT;
            w_len_nxt   = w_len_eff;
          end
        end
        ACCUM: begin
          if (w_cnt_inc == r_len) begin
            w_done      = 1'b1;
            w_done_sum  = w_acc_add;
            w_done_max  = w_max_upd;
            w_done_cnt  = w_cnt_inc;
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_max_nxt   = '0;
            w_cnt_nxt   = '0;
            w_len_nxt   = '0;
          end else begin
            w_acc_nxt   = w_acc_add;
            w_max_nxt   = w_max_upd;
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_max_nxt   = '0;
          w_cnt_nxt   = '0;
          w_len_nxt   = '0;
        end
      endcase
    end
  end

  // Window state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_max   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_max   <= w_max_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // A result is taken when the holding register is empty or being emptied
  always_comb begin
    w_load = w_done && (!r_out_valid || bus.out_ready);
    w_drop = w_done && r_out_valid && !bus.out_ready;
  end

  // Holding register and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_max   <= '0;
      r_out_cnt   <= '0;
      r_ovr       <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_sum   <= w_done_sum;
        r_out_max   <= w_done_max;
        r_out_cnt   <= w_done_cnt;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_max   = r_out_max;
  assign bus.out_cnt   = r_out_cnt;
  assign bus.ovr       = r_ovr;

endmodule

// File: tb/tb_adder_ds_acc.sv
// Testbench for adder_ds_acc: directed scenarios with literal expectations
// followed by a randomized run, all compared every cycle against a
// queue-based window model.
module tb_adder_ds_acc;

  localparam int N     = 32;
  localparam int WIN_W = 4;
  localparam int ACC_W = N + WIN_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int total = 0;
  int bad   = 0;

  adder_ds_acc_if #(.N(N), .WIN_W(WIN_W), .ACC_W(ACC_W)) bus ();

  adder_ds_acc #(.N(N), .WIN_W(WIN_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0]     winQ[$];
  int               winL    = 0;
  logic             mValid  = 1'b0;
  logic [ACC_W-1:0] mSum    = '0;
  logic [N-1:0]     mMax    = '0;
  logic [WIN_W:0]   mCnt    = '0;
  logic             mOvr    = 1'b0;
  logic             mDone;
  logic [ACC_W-1:0] mResSum;
  logic [N-1:0]     mResMax;
  logic [WIN_W:0]   mResCnt;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [N-1:0] d,
                               input logic [WIN_W-1:0] wl, input logic fl,
                               input logic rdy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.win_len   = wl;
    bus.flush     = fl;
    bus.out_ready = rdy;
  endtask

  // Window model: the samples of the open window sit in a queue; a window
  // closes when the queue reaches the length latched at its first sample
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winQ.delete();
      winL   = 0;
      mValid = 1'b0;
      mSum   = '0;
      mMax   = '0;
      mCnt   = '0;
      mOvr   = 1'b0;
    end else begin
      mDone = 1'b0;
      if (bus.flush) begin
        winQ.delete();
      end else if (bus.in_valid) begin
        if (winQ.size() == 0)
          winL = (bus.win_len == '0) ? (1 << WIN_W) : int'(bus.win_len);
        winQ.push_back(bus.in_data);
        if (winQ.size() == winL) begin
          mResSum = '0;
          mResMax = '0;
          foreach (winQ[i]) begin
            mResSum = mResSum + ACC_W'(winQ[i]);
            if (winQ[i] > mResMax) mResMax = winQ[i];
          end
          mResCnt = (WIN_W+1)'(winQ.size());
          mDone   = 1'b1;
          winQ.delete();
        end
      end
      if (mDone) begin
        if (!mValid || bus.out_ready) begin
          mValid = 1'b1;
          mSum   = mResSum;
          mMax   = mResMax;
          mCnt   = mResCnt;
        end else begin
          mOvr = 1'b1;
        end
      end else if (mValid && bus.out_ready) begin
        mValid = 1'b0;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    checkOutput("out_valid", 64'(bus.out_valid), 64'(mValid));
    checkOutput("ovr", 64'(bus.ovr), 64'(mOvr));
    if (mValid) begin
      checkOutput("out_sum", 64'(bus.out_sum), 64'(mSum));
      checkOutput("out_max", 64'(bus.out_max), 64'(mMax));
      checkOutput("out_cnt", 64'(bus.out_cnt), 64'(mCnt));
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.win_len   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset out_sum", 64'(bus.out_sum), 64'd0);
    checkOutput("reset ovr", 64'(bus.ovr), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic 3-sample window
    applyStimulus(1, 5, 3, 0, 1);
    applyStimulus(1, 7, 3, 0, 1);
    applyStimulus(1, 2, 3, 0, 1);
    applyStimulus(0, 0, 3, 0, 1);
    checkOutput("w3 valid", 64'(bus.out_valid), 64'd1);
    checkOutput("w3 sum", 64'(bus.out_sum), 64'd14);
    checkOutput("w3 max", 64'(bus.out_max), 64'd7);
    checkOutput("w3 cnt", 64'(bus.out_cnt), 64'd3);
    applyStimulus(0, 0, 3, 0, 1);
    checkOutput("w3 valid falls", 64'(bus.out_valid), 64'd0);

    // Full-length window of all-ones samples
    for (int i = 0; i < 16; i++) applyStimulus(1, 32'hFFFF_FFFF, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("w16 sum", 64'(bus.out_sum), 64'hF_FFFF_FFF0);
    checkOutput("w16 cnt", 64'(bus.out_cnt), 64'd16);
    checkOutput("w16 max", 64'(bus.out_max), 64'hFFFF_FFFF);
    checkOutput("w16 ovr", 64'(bus.ovr), 64'd0);

    // Overrun: second result dropped while the first is held
    applyStimulus(1, 1, 2, 0, 0);
    applyStimulus(1, 2, 2, 0, 0);
    applyStimulus(1, 3, 2, 0, 0);
    applyStimulus(1, 4, 2, 0, 0);
    applyStimulus(0, 0, 2, 0, 1);
    checkOutput("ovr held sum", 64'(bus.out_sum), 64'd3);
    checkOutput("ovr flag", 64'(bus.ovr), 64'd1);
    checkOutput("ovr held valid", 64'(bus.out_valid), 64'd1);
    applyStimulus(0, 0, 2, 0, 1);
    checkOutput("ovr drained", 64'(bus.out_valid), 64'd0);

    // Back-to-back windows with a ready consumer
    applyStimulus(1, 1, 2, 0, 1);
    applyStimulus(1, 2, 2, 0, 1);
    applyStimulus(1, 3, 2, 0, 1);
    checkOutput("b2b sum a", 64'(bus.out_sum), 64'd3);
    applyStimulus(1, 4, 2, 0, 1);
    applyStimulus(1, 3, 1, 0, 1);
    checkOutput("b2b sum b", 64'(bus.out_sum), 64'd7);
    applyStimulus(1, 7, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("len1 valid stays", 64'(bus.out_valid), 64'd1);
    checkOutput("len1 sum", 64'(bus.out_sum), 64'd7);

    // Flush discards the partial window and its own sample
    applyStimulus(1, 9, 4, 0, 1);
    applyStimulus(1, 1, 4, 0, 1);
    applyStimulus(1, 6, 4, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 2, 4, 0, 1);
    applyStimulus(0, 0, 4, 0, 1);
    checkOutput("flush sum", 64'(bus.out_sum), 64'd8);
    checkOutput("flush max", 64'(bus.out_max), 64'd2);
    checkOutput("flush cnt", 64'(bus.out_cnt), 64'd4);

    // Asynchronous reset in mid-window with a result held
    applyStimulus(1, 9, 1, 0, 0);
    applyStimulus(1, 4, 3, 0, 0);
    applyStimulus(1, 4, 3, 0, 0);
    applyStimulus(0, 0, 3, 0, 0);
    checkOutput("pre-reset valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async valid", 64'(bus.out_valid), 64'd0);
    checkOutput("async sum", 64'(bus.out_sum), 64'd0);
    checkOutput("async max", 64'(bus.out_max), 64'd0);
    checkOutput("async ovr", 64'(bus.ovr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1, 3, 0, 1);
    applyStimulus(1, 1, 3, 0, 1);
    applyStimulus(1, 1, 3, 0, 1);
    applyStimulus(0, 0, 3, 0, 1);
    checkOutput("post-reset sum", 64'(bus.out_sum), 64'd3);
    checkOutput("post-reset cnt", 64'(bus.out_cnt), 64'd3);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [N-1:0]     d;
      logic [WIN_W-1:0] wl;
      d  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      wl = ($urandom_range(0, 3) == 0) ? WIN_W'($urandom_range(0, 15))
                                       : WIN_W'($urandom_range(1, 3));
      applyStimulus(logic'($urandom_range(0, 3) != 0), d, wl,
                    logic'($urandom_range(0, 39) == 0),
                    logic'($urandom_range(0, 2) != 0));
    end
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
